// File: rtl/mul_div_unit.sv
// 8051 MUL AB / DIV AB engine: shift-add multiplier and restoring divider
// sharing one 8-iteration sequencer; flags feed the PSW on the done cycle.
module mul_div_unit #(
    parameter logic [1:0] PSW_NOP   = 2'b00,
    parameter logic [1:0] PSW_CY_OV = 2'b01
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       op,
    input  logic [7:0] acc_in,
    input  logic [7:0] b_in,
    output logic       busy,
    output logic       done,
    output logic [7:0] acc_out,
    output logic [7:0] b_out,
    output logic       carry_out,
    output logic       overflow_out,
    output logic [1:0] psw_set
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Handshake: start is accepted on a rising edge only in IDLE or DONE;
    // done is a one-cycle pulse and the result ports hold until the next done.

    state_t      state, state_next;
    logic        op_q;
    logic [7:0]  hi_q, lo_q, b_q, a_q;
    logic [2:0]  count_q;
    logic        accept;

    logic [8:0]  mul_sum;
    logic [8:0]  div_shift;
    logic [7:0]  div_diff;
    logic        div_ok;
    logic [7:0]  hi_next, lo_next;

    assign accept    = start && (state == IDLE || state == DONE);
    assign carry_out = 1'b0;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        psw_set    = PSW_NOP;
        case (state)
            IDLE: begin
                if (start) state_next = CALC;
            end
            CALC: begin
                busy = 1'b1;
                if (count_q == 3'd0) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                psw_set    = PSW_CY_OV;
                state_next = start ? CALC : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // hi_q:lo_q is the 16-bit partial product for MUL, remainder:dividend for DIV.
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : 9'd0);
        div_shift = {hi_q, lo_q[7]};
        div_ok    = (div_shift >= {1'b0, b_q});
        div_diff  = div_shift[7:0] - b_q;
        if (op_q) begin
            hi_next = div_ok ? div_diff : div_shift[7:0];
            lo_next = {lo_q[6:0], div_ok};
        end else begin
            hi_next = mul_sum[8:1];
            lo_next = {mul_sum[0], lo_q[7:1]};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            op_q         <= 1'b0;
            hi_q         <= 8'h00;
            lo_q         <= 8'h00;
            a_q          <= 8'h00;
            b_q          <= 8'h00;
            count_q      <= 3'd0;
            acc_out      <= 8'h00;
            b_out        <= 8'h00;
            overflow_out <= 1'b0;
        end else if (accept) begin
            op_q    <= op;
            lo_q    <= acc_in;
            a_q     <= acc_in;
            b_q     <= b_in;
            hi_q    <= 8'h00;
            count_q <= 3'd7;
        end else if (state == CALC) begin
            hi_q    <= hi_next;
            lo_q    <= lo_next;
            count_q <= count_q - 3'd1;
            if (count_q == 3'd0) begin
                if (op_q && b_q == 8'h00) begin
                    // Divide by zero: 8051 leaves an undefined result; report OV.
                    acc_out      <= 8'hFF;
                    b_out        <= a_q;
                    overflow_out <= 1'b1;
                end else begin
                    acc_out      <= lo_next;
                    b_out        <= hi_next;
                    overflow_out <= !op_q && (hi_next != 8'h00);
                end
            end
        end
    end

endmodule
